// File: rtl/pam_mul_share_sched_if.sv
// Request/response bundle for the shared-multiplier scheduler.
// master = requester/consumer side, slave = scheduler side.
interface pam_mul_share_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_x;
    logic [8*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_apx;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_z;
    logic              busy;
    logic [15:0]       op_cnt;

    modport master (
        output req_valid, req_x, req_y, req_apx, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, busy, op_cnt
    );

    modport slave (
        input  req_valid, req_x, req_y, req_apx, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, busy, op_cnt
    );
endinterface

// File: rtl/pam_mul_share_sched.sv
// Round-robin scheduler sharing one 8x8 multiplier (exact or l=2 approximate)
// among NREQ requesters through a two-stage operand/product pipeline.
module pam_mul_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pam_mul_share_sched_if.slave bus
);
    logic           r_v1;
    logic [7:0]     r_x1;
    logic [7:0]     r_y1;
    logic           r_apx1;
    logic [IDW-1:0] r_id1;
    logic           r_v2;
    logic [15:0]    r_z2;
    logic [IDW-1:0] r_id2;
    logic [IDW-1:0] r_ptr;
    logic [15:0]    r_opCnt;

    logic           w_s2Load;
    logic           w_s1Free;
    logic           w_grant;
    logic [IDW-1:0] w_gid;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_cand;
    logic [7:0]     w_pp0;
    logic [7:0]     w_pp1;
    logic [15:0]    w_partial;
    logic [15:0]    w_a;
    logic [15:0]    w_b;
    logic [15:0]    w_zExact;
    logic [15:0]    w_zApx;
    logic [15:0]    w_z;

    assign w_s2Load = r_v1 & (~r_v2 | bus.rsp_ready);
    assign w_s1Free = ~r_v1 | w_s2Load;

    // First valid requester at or after the pointer wins; nothing is granted while S1 is blocked.
    always_comb begin
        w_grant = 1'b0;
        w_gid   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_cand = w_sum[IDW-1:0];
            if (!w_grant && bus.req_valid[w_cand]) begin
                w_grant = 1'b1;
                w_gid   = w_cand;
            end
        end
        w_grant = w_grant & w_s1Free & rst_n;
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_grant) begin
            bus.req_ready[w_gid] = 1'b1;
        end
    end

    // Approximate mode: rows 2..7 exact, rows 0/1 replaced by the exchanged-bit terms A and B.
    assign w_pp0     = r_y1 & {8{r_x1[0]}};
    assign w_pp1     = r_y1 & {8{r_x1[1]}};
    assign w_partial = 16'(r_y1) * 16'(r_x1[7:2]);
    assign w_a       = {7'b0, w_pp0[7] & w_pp1[6], w_pp0[7] | w_pp1[6], w_pp0[5] | w_pp1[5], 6'b0};
    assign w_b       = {7'b0, w_pp1[7], 8'b0};
    assign w_zApx    = (w_partial << 2) + w_a + w_b;
    assign w_zExact  = 16'(r_x1) * 16'(r_y1);
    assign w_z       = r_apx1 ? w_zApx : w_zExact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_apx1  <= 1'b0;
            r_id1   <= '0;
            r_v2    <= 1'b0;
            r_z2    <= '0;
            r_id2   <= '0;
            r_ptr   <= '0;
            r_opCnt <= '0;
        end else begin
            if (w_grant) begin
                r_v1   <= 1'b1;
                r_x1   <= bus.req_x[8*w_gid +: 8];
                r_y1   <= bus.req_y[8*w_gid +: 8];
                r_apx1 <= bus.req_apx[w_gid];
                r_id1  <= w_gid;
                r_ptr  <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
            end else if (w_s2Load) begin
                r_v1 <= 1'b0;
            end

            if (w_s2Load) begin
                r_v2  <= 1'b1;
                r_z2  <= w_z;
                r_id2 <= r_id1;
            end else if (bus.rsp_ready) begin
                r_v2 <= 1'b0;
            end

            if (r_v2 && bus.rsp_ready) begin
                r_opCnt <= r_opCnt + 16'd1;
            end
        end
    end

    assign bus.rsp_valid = r_v2;
    assign bus.rsp_id    = r_id2;
    assign bus.rsp_z     = r_z2;
    assign bus.busy      = r_v1 | r_v2;
    assign bus.op_cnt    = r_opCnt;
endmodule

// File: tb/tb_pam_mul_share_sched.sv
// Self-checking bench for pam_mul_share_sched: constant vectors, directed
// multi-cycle sequences and random traffic against a queue-based model.
module tb_pam_mul_share_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;

    pam_mul_share_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    pam_mul_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         id;
        logic [7:0] x;
        logic [7:0] y;
        bit         apx;
        int         age;
    } op_t;

    typedef struct {
        int          id;
        logic [7:0]  x;
        logic [7:0]  y;
        bit          apx;
        logic [15:0] expZ;
    } vec_t;

    int          nCompared;
    int          nFailed;
    bit          pendV [NREQ];
    logic [7:0]  pendX [NREQ];
    logic [7:0]  pendY [NREQ];
    bit          pendA [NREQ];
    bit          rr;
    op_t         q[$];
    int          mPtr;
    logic [15:0] mCnt;
    bit          gotRsp;
    logic [15:0] gotZ;
    logic [IDW-1:0] gotId;
    vec_t        vecs[$];

    // Product straight from the partial-product definition: sum of shifted rows.
    function automatic logic [15:0] refMul(input logic [7:0] x, input logic [7:0] y, input bit apx);
        int         acc;
        logic [7:0] p0;
        logic [7:0] p1;
        if (!apx) return 16'(int'(x) * int'(y));
        acc = 0;
        for (int k = 2; k < 8; k++) begin
            if (x[k]) acc += int'(y) << k;
        end
        p0 = x[0] ? y : 8'd0;
        p1 = x[1] ? y : 8'd0;
        acc += int'(p0[5] | p1[5]) * 64;
        acc += int'(p0[7] | p1[6]) * 128;
        acc += int'(p0[7] & p1[6]) * 256;
        acc += int'(p1[7]) * 256;
        return acc[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int r = 0; r < NREQ; r++) begin
            bus.req_valid[r]       = pendV[r];
            bus.req_x[8*r +: 8]    = pendX[r];
            bus.req_y[8*r +: 8]    = pendY[r];
            bus.req_apx[r]         = pendA[r];
        end
        bus.rsp_ready = rr;
    endtask

    task automatic newOp(input int r);
        pendV[r] = 1'b1;
        pendX[r] = 8'($urandom);
        pendY[r] = 8'($urandom);
        pendA[r] = 1'($urandom_range(0, 1));
    endtask

    task automatic clearPend();
        for (int r = 0; r < NREQ; r++) pendV[r] = 1'b0;
    endtask

    task automatic modelReset();
        q.delete();
        mPtr = 0;
        mCnt = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_rsp_id"},    bus.rsp_id, 0);
        checkOutput({tag, "_rsp_z"},     bus.rsp_z, 0);
        checkOutput({tag, "_busy"},      bus.busy, 0);
        checkOutput({tag, "_op_cnt"},    bus.op_cnt, 0);
    endtask

    // One clock: drive, check at negedge against the in-flight queue, advance model.
    task automatic stepCycle();
        bit              frontVis;
        bit              allow;
        int              g;
        int              c;
        logic [NREQ-1:0] expReady;
        op_t             e;
        applyStimulus();
        @(negedge clk);
        frontVis = (q.size() > 0) && (q[0].age >= 2);
        allow    = (q.size() < 2) || (frontVis && rr);
        g        = -1;
        expReady = '0;
        if (allow) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (mPtr + k) % NREQ;
                if (g < 0 && pendV[c]) g = c;
            end
        end
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", bus.req_ready, expReady);
        checkOutput("rsp_valid", bus.rsp_valid, frontVis);
        if (frontVis) begin
            checkOutput("rsp_id", bus.rsp_id, q[0].id);
            checkOutput("rsp_z", bus.rsp_z, refMul(q[0].x, q[0].y, q[0].apx));
        end
        checkOutput("busy", bus.busy, q.size() > 0);
        checkOutput("op_cnt", bus.op_cnt, mCnt);
        if (bus.rsp_valid && rr) begin
            gotRsp = 1'b1;
            gotZ   = bus.rsp_z;
            gotId  = bus.rsp_id;
        end
        if (frontVis && rr) begin
            void'(q.pop_front());
            mCnt = mCnt + 16'd1;
        end
        foreach (q[i]) q[i].age++;
        if (g >= 0) begin
            e = '{id: g, x: pendX[g], y: pendY[g], apx: pendA[g], age: 1};
            q.push_back(e);
            mPtr     = (g + 1) % NREQ;
            pendV[g] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic refillAll();
        for (int r = 0; r < NREQ; r++) begin
            if (!pendV[r]) newOp(r);
        end
    endtask

    initial begin
        nCompared = 0;
        nFailed   = 0;
        rr        = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            pendV[r] = 1'b1;
            pendX[r] = 8'(r + 1);
            pendY[r] = 8'(r + 7);
            pendA[r] = 1'b0;
        end
        modelReset();

        vecs.push_back('{id: 0, x: 8'd255, y: 8'd255, apx: 1'b0, expZ: 16'd65025});
        vecs.push_back('{id: 1, x: 8'd255, y: 8'd255, apx: 1'b1, expZ: 16'd64964});
        vecs.push_back('{id: 2, x: 8'd3,   y: 8'd200, apx: 1'b1, expZ: 16'd640});
        vecs.push_back('{id: 3, x: 8'd3,   y: 8'd200, apx: 1'b0, expZ: 16'd600});
        vecs.push_back('{id: 0, x: 8'd2,   y: 8'd255, apx: 1'b1, expZ: 16'd448});
        vecs.push_back('{id: 1, x: 8'd2,   y: 8'd255, apx: 1'b0, expZ: 16'd510});
        vecs.push_back('{id: 2, x: 8'd1,   y: 8'd128, apx: 1'b1, expZ: 16'd128});
        vecs.push_back('{id: 3, x: 8'd4,   y: 8'd1,   apx: 1'b1, expZ: 16'd4});
        vecs.push_back('{id: 1, x: 8'd0,   y: 8'd173, apx: 1'b1, expZ: 16'd0});

        rst_n = 1'b0;
        applyStimulus();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetOutputs("reset");
        clearPend();
        applyStimulus();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            pendV[vecs[i].id] = 1'b1;
            pendX[vecs[i].id] = vecs[i].x;
            pendY[vecs[i].id] = vecs[i].y;
            pendA[vecs[i].id] = vecs[i].apx;
            gotRsp = 1'b0;
            for (int cyc = 0; cyc < 8 && !gotRsp; cyc++) stepCycle();
            if (!gotRsp) begin
                checkOutput("vec_timeout", 0, 1);
            end else begin
                checkOutput("vec_z", gotZ, vecs[i].expZ);
                checkOutput("vec_id", gotId, vecs[i].id);
            end
        end

        $display("[TB] round-robin stream");
        for (int cyc = 0; cyc < 12; cyc++) begin
            refillAll();
            stepCycle();
        end

        $display("[TB] response stall");
        rr = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            refillAll();
            stepCycle();
        end
        rr = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            refillAll();
            stepCycle();
        end
        clearPend();
        for (int cyc = 0; cyc < 4; cyc++) stepCycle();

        $display("[TB] pointer wrap");
        newOp(3);
        for (int cyc = 0; cyc < 4 && pendV[3]; cyc++) stepCycle();
        checkOutput("wrap_ptr_model", mPtr, 0);
        newOp(2);
        stepCycle();
        checkOutput("wrap_req2_taken", pendV[2], 0);
        for (int cyc = 0; cyc < 4; cyc++) stepCycle();

        $display("[TB] reset with both stages full");
        rr = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            refillAll();
            stepCycle();
        end
        checkOutput("pre_reset_busy", bus.busy, 1);
        checkOutput("pre_reset_rsp_valid", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearPend();
        rr = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) stepCycle();

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!pendV[r] && $urandom_range(0, 1) == 1) newOp(r);
            end
            rr = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        clearPend();
        rr = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
